// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road junction phase sequencer.
// PED_WALK is only reachable when PED_REQUEST_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLR_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLR_B     = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int unsigned T_GREEN_DEF  = 10;
    localparam int unsigned T_YELLOW_DEF = 3;
    localparam int unsigned T_ALLRED_DEF = 1;
    localparam int unsigned T_WALK_DEF   = 5;

    // delay_s would never time out on 0, so a zero duration becomes 1
    function automatic logic [31:0] clamp_dur(input int unsigned v);
        return (v == 0) ? 32'd1 : 32'(v);
    endfunction

endpackage

// File: rtl/phase_delay_sel.sv
// Maps the current phase to the 32-bit duration presented to delay_s.
// Unknown encodings get the all-red clearance time.
module phase_delay_sel
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN  = T_GREEN_DEF,
    parameter int unsigned T_YELLOW = T_YELLOW_DEF,
    parameter int unsigned T_ALLRED = T_ALLRED_DEF,
    parameter int unsigned T_WALK   = T_WALK_DEF
) (
    input  state_t      state_i,
    output logic [31:0] delay_o
);

    always_comb begin
        delay_o = clamp_dur(T_ALLRED);
        case (state_i)
            NS_GREEN, EW_GREEN:   delay_o = clamp_dur(T_GREEN);
            NS_YELLOW, EW_YELLOW: delay_o = clamp_dur(T_YELLOW);
            CLR_A, CLR_B:         delay_o = clamp_dur(T_ALLRED);
            PED_WALK:             delay_o = clamp_dur(T_WALK);
            default:              delay_o = clamp_dur(T_ALLRED);
        endcase
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road junction phase sequencer driving delay_s and the lamp outputs.
// Optional pedestrian walk phase is enabled by defining PED_REQUEST_EN.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN  = T_GREEN_DEF,
    parameter int unsigned T_YELLOW = T_YELLOW_DEF,
    parameter int unsigned T_ALLRED = T_ALLRED_DEF,
    parameter int unsigned T_WALK   = T_WALK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timeout,
    input  logic        ped_req,
    output logic [31:0] delay,
    output logic        tmr_rst,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        ped_walk
);

    state_t     state_q, state_d;
    logic       tmr_rst_q, blank_q;
    logic [2:0] ns_q, ns_d, ew_q, ew_d;
    logic       walk_d;
    logic       advance;

    // timeout from delay_s may still be high from the previous phase for
    // the restart cycle and the one after it
    assign advance = timeout && !tmr_rst_q && !blank_q;

`ifdef PED_REQUEST_EN
    logic ped_q, ped_d;
    logic ret_ew_q;
    logic walk_q;

    assign ped_d = ((state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : ped_q) | ped_req;
`else
    logic unused_ped;
    assign unused_ped = ped_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLR_B;
            tmr_rst_q <= 1'b1;
            blank_q   <= 1'b1;
            ns_q      <= LAMP_RED;
            ew_q      <= LAMP_RED;
`ifdef PED_REQUEST_EN
            ped_q     <= 1'b0;
            ret_ew_q  <= 1'b0;
            walk_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_rst_q <= (state_d != state_q);
            blank_q   <= tmr_rst_q;
            ns_q      <= ns_d;
            ew_q      <= ew_d;
`ifdef PED_REQUEST_EN
            ped_q     <= ped_d;
            walk_q    <= walk_d;
            if (state_d == PED_WALK && state_q != PED_WALK)
                ret_ew_q <= (state_q == CLR_A);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  if (advance) state_d = NS_YELLOW;
            NS_YELLOW: if (advance) state_d = CLR_A;
`ifdef PED_REQUEST_EN
            CLR_A:     if (advance) state_d = ped_q ? PED_WALK : EW_GREEN;
            CLR_B:     if (advance) state_d = ped_q ? PED_WALK : NS_GREEN;
            PED_WALK:  if (advance) state_d = ret_ew_q ? EW_GREEN : NS_GREEN;
`else
            CLR_A:     if (advance) state_d = EW_GREEN;
            CLR_B:     if (advance) state_d = NS_GREEN;
`endif
            EW_GREEN:  if (advance) state_d = EW_YELLOW;
            EW_YELLOW: if (advance) state_d = CLR_B;
            default:   state_d = CLR_B;
        endcase
    end

    // lamps decode from next-state so they flip on the same edge as the state
    always_comb begin
        ns_d   = LAMP_RED;
        ew_d   = LAMP_RED;
        walk_d = 1'b0;
        case (state_d)
            NS_GREEN:  ns_d = LAMP_GRN;
            NS_YELLOW: ns_d = LAMP_YEL;
            EW_GREEN:  ew_d = LAMP_GRN;
            EW_YELLOW: ew_d = LAMP_YEL;
`ifdef PED_REQUEST_EN
            PED_WALK:  walk_d = 1'b1;
`endif
            default:   ;
        endcase
    end

    phase_delay_sel #(
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .T_WALK   (T_WALK)
    ) u_dly (
        .state_i (state_q),
        .delay_o (delay)
    );

    assign tmr_rst  = tmr_rst_q;
    assign ns_light = ns_q;
    assign ew_light = ew_q;
`ifdef PED_REQUEST_EN
    assign ped_walk = walk_q;
`else
    logic unused_walk;
    assign unused_walk = walk_d;
    assign ped_walk    = 1'b0;
`endif

endmodule
